// File: rtl/pipe_decode_if.sv
// rtl/pipe_decode_if.sv - ID-stage bus between IF/ID, later stages and the ID/EX register
interface pipe_decode_if #(
    parameter int XLEN = 32
);
    logic [31:0]     inst;
    logic            id_valid;
    logic [XLEN-1:0] dpc4;
    logic [4:0]      ern;
    logic [4:0]      mrn;
    logic [4:0]      wrn;
    logic            ewreg;
    logic            em2reg;
    logic            mwreg;
    logic            mm2reg;
    logic            wwreg;
    logic [XLEN-1:0] ealu;
    logic [XLEN-1:0] malu;
    logic [XLEN-1:0] mmo;
    logic [XLEN-1:0] wdi;

    logic [XLEN-1:0] bpc;
    logic [XLEN-1:0] jpc;
    logic [XLEN-1:0] rpc;
    logic [1:0]      pcsource;
    logic            wpcir;
    logic            flush_if;
    logic            e_valid;
    logic            e_wreg;
    logic            e_m2reg;
    logic            e_wmem;
    logic            e_aluimm;
    logic            e_shift;
    logic            e_jal;
    logic [3:0]      e_aluc;
    logic [XLEN-1:0] e_a;
    logic [XLEN-1:0] e_b;
    logic [XLEN-1:0] e_imm;
    logic [XLEN-1:0] e_pc4;
    logic [4:0]      e_rn;
    logic [15:0]     stall_count;

    modport slave (
        input  inst, id_valid, dpc4, ern, mrn, wrn,
        input  ewreg, em2reg, mwreg, mm2reg, wwreg,
        input  ealu, malu, mmo, wdi,
        output bpc, jpc, rpc, pcsource, wpcir, flush_if,
        output e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal,
        output e_aluc, e_a, e_b, e_imm, e_pc4, e_rn, stall_count
    );

    modport master (
        output inst, id_valid, dpc4, ern, mrn, wrn,
        output ewreg, em2reg, mwreg, mm2reg, wwreg,
        output ealu, malu, mmo, wdi,
        input  bpc, jpc, rpc, pcsource, wpcir, flush_if,
        input  e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal,
        input  e_aluc, e_a, e_b, e_imm, e_pc4, e_rn, stall_count
    );
endinterface

// File: rtl/pipe_decode.sv
// rtl/pipe_decode.sv - MIPS-subset ID stage: regfile, decode, forwarding, interlock, branch, ID/EX register
// Optional branch delay slot: define PIPEDECODE_DELAY_SLOT_EN.
module pipe_decode #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clock,
    input  logic         reset,
    pipe_decode_if.slave bus
);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign op  = bus.inst[31:26];
    assign rs  = bus.inst[25:21];
    assign rt  = bus.inst[20:16];
    assign rd  = bus.inst[15:11];
    assign fn  = bus.inst[5:0];
    assign imm = bus.inst[15:0];

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type & (fn == 6'b100000);
    assign i_sub  = r_type & (fn == 6'b100010);
    assign i_and  = r_type & (fn == 6'b100100);
    assign i_or   = r_type & (fn == 6'b100101);
    assign i_xor  = r_type & (fn == 6'b100110);
    assign i_sll  = r_type & (fn == 6'b000000);
    assign i_srl  = r_type & (fn == 6'b000010);
    assign i_sra  = r_type & (fn == 6'b000011);
    assign i_jr   = r_type & (fn == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lui  = (op == 6'b001111);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    logic r_alu, r_shift, i_alu;
    logic c_wreg, c_m2reg, c_wmem, c_aluimm, c_regrt, c_sext;
    logic use_rs, use_rt;
    logic [3:0] c_aluc;

    assign r_alu    = i_add | i_sub | i_and | i_or | i_xor;
    assign r_shift  = i_sll | i_srl | i_sra;
    assign i_alu    = i_addi | i_andi | i_ori | i_xori;
    assign c_wreg   = r_alu | r_shift | i_alu | i_lui | i_lw | i_jal;
    assign c_m2reg  = i_lw;
    assign c_wmem   = i_sw;
    assign c_aluimm = i_alu | i_lui | i_lw | i_sw;
    assign c_regrt  = i_alu | i_lui | i_lw;
    assign c_sext   = i_addi | i_lw | i_sw | i_beq | i_bne;
    // Shifts take their amount from sa, so rs is not a dependency for them.
    assign use_rs   = r_alu | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne;
    assign use_rt   = r_alu | r_shift | i_sw | i_beq | i_bne;

    always_comb begin
        c_aluc = 4'b0000;
        if (i_sub | i_beq | i_bne)  c_aluc = 4'b0100;
        else if (i_and | i_andi)    c_aluc = 4'b0001;
        else if (i_or | i_ori)      c_aluc = 4'b0101;
        else if (i_xor | i_xori)    c_aluc = 4'b0010;
        else if (i_lui)             c_aluc = 4'b0110;
        else if (i_sll)             c_aluc = 4'b0011;
        else if (i_srl)             c_aluc = 4'b0111;
        else if (i_sra)             c_aluc = 4'b1111;
    end

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic            wb_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wwreg && bus.wrn != 5'd0) begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.wrn == 5'(i)) regs[i] <= bus.wdi;
            end
        end
    end

    // Register 0 is never read from the array; unimplemented indices stay 0.
    always_comb begin
        rf_a  = '0;
        rf_b  = '0;
        wb_ok = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs == 5'(i))      rf_a  = regs[i];
            if (rt == 5'(i))      rf_b  = regs[i];
            if (bus.wrn == 5'(i)) wb_ok = bus.wwreg;
        end
        if (wb_ok && bus.wrn == rs) rf_a = bus.wdi;
        if (wb_ok && bus.wrn == rt) rf_b = bus.wdi;
    end

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] m_val;

    assign m_val = bus.mm2reg ? bus.mmo : bus.malu;

    always_comb begin
        fa = rf_a;
        fb = rf_b;
        if (bus.mwreg && bus.mrn != 5'd0 && bus.mrn == rs) fa = m_val;
        if (bus.mwreg && bus.mrn != 5'd0 && bus.mrn == rt) fb = m_val;
        if (bus.ewreg && !bus.em2reg && bus.ern != 5'd0 && bus.ern == rs) fa = bus.ealu;
        if (bus.ewreg && !bus.em2reg && bus.ern != 5'd0 && bus.ern == rt) fb = bus.ealu;
    end

    logic stall;
    logic go;
    logic taken;
    logic [1:0] ps;

    assign stall = bus.id_valid & bus.ewreg & bus.em2reg & (bus.ern != 5'd0) &
                   ((use_rs & (bus.ern == rs)) | (use_rt & (bus.ern == rt)));
    assign go    = bus.id_valid & ~stall;
    assign taken = (i_beq & (fa == fb)) | (i_bne & (fa != fb));

    always_comb begin
        ps = 2'b00;
        if (!reset && go) begin
            if (i_jr)              ps = 2'b10;
            else if (i_j | i_jal)  ps = 2'b11;
            else if (taken)        ps = 2'b01;
        end
    end

    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] link;

    assign imm_sx  = {{(XLEN-16){imm[15]}}, imm};
    assign imm_ext = c_sext ? imm_sx : {{(XLEN-16){1'b0}}, imm};

    assign bus.pcsource = ps;
    assign bus.wpcir    = reset | ~stall;
    assign bus.bpc      = bus.dpc4 + {imm_sx[XLEN-3:0], 2'b00};
    assign bus.jpc      = {bus.dpc4[XLEN-1:28], bus.inst[25:0], 2'b00};
    assign bus.rpc      = fa;

`ifdef PIPEDECODE_DELAY_SLOT_EN
    assign bus.flush_if = 1'b0;
    assign link         = bus.dpc4 + XLEN'(4);
`else
    assign bus.flush_if = (ps != 2'b00);
    assign link         = bus.dpc4;
`endif

    // Reset, a bubble in ID and a load-use stall all load the same all-zero bubble.
    always_ff @(posedge clock) begin
        if (reset || !go) begin
            bus.e_valid  <= 1'b0;
            bus.e_wreg   <= 1'b0;
            bus.e_m2reg  <= 1'b0;
            bus.e_wmem   <= 1'b0;
            bus.e_aluimm <= 1'b0;
            bus.e_shift  <= 1'b0;
            bus.e_jal    <= 1'b0;
            bus.e_aluc   <= 4'b0000;
            bus.e_a      <= '0;
            bus.e_b      <= '0;
            bus.e_imm    <= '0;
            bus.e_pc4    <= '0;
            bus.e_rn     <= 5'd0;
        end else begin
            bus.e_valid  <= 1'b1;
            bus.e_wreg   <= c_wreg;
            bus.e_m2reg  <= c_m2reg;
            bus.e_wmem   <= c_wmem;
            bus.e_aluimm <= c_aluimm;
            bus.e_shift  <= r_shift;
            bus.e_jal    <= i_jal;
            bus.e_aluc   <= c_aluc;
            bus.e_a      <= fa;
            bus.e_b      <= fb;
            bus.e_imm    <= imm_ext;
            bus.e_pc4    <= i_jal ? link : bus.dpc4;
            bus.e_rn     <= i_jal ? 5'd31 : (c_regrt ? rt : rd);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.stall_count <= 16'd0;
        end else if (stall && bus.stall_count != 16'hFFFF) begin
            bus.stall_count <= bus.stall_count + 16'd1;
        end
    end
endmodule
